// File: rtl/rob_recovery_ctrl_if.sv
// Handshake bundle between the ROB/memory side and the recovery controller.
// The master drives squash/halt/drain status; the slave (controller) drives recovery control.
interface rob_recovery_ctrl_if #(
    parameter int MEM_CNT_W = 4
);
    logic                 squash;
    logic [31:0]          squash_target;
    logic                 ct_halt;
    logic                 sq_empty;
    logic [MEM_CNT_W-1:0] mem_outstanding;

    logic                 flush;
    logic                 stall_dispatch;
    logic                 restore_valid;
    logic [4:0]           restore_arn_base;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic                 halted;
    logic                 drain_timeout;
    logic [15:0]          recovery_cycles;

    modport master (
        output squash, squash_target, ct_halt, sq_empty, mem_outstanding,
        input  flush, stall_dispatch, restore_valid, restore_arn_base,
               redirect_valid, redirect_pc, halted, drain_timeout, recovery_cycles
    );

    modport slave (
        input  squash, squash_target, ct_halt, sq_empty, mem_outstanding,
        output flush, stall_dispatch, restore_valid, restore_arn_base,
               redirect_valid, redirect_pc, halted, drain_timeout, recovery_cycles
    );
endinterface

// File: rtl/rob_recovery_ctrl.sv
// Pipeline recovery sequencer: FLUSH -> DRAIN -> RESTORE map walk -> REDIRECT fetch.
// A committed halt parks the machine in HALTED until reset.
module rob_recovery_ctrl #(
    parameter int ARCH_REGS     = 32,
    parameter int RESTORE_WIDTH = 4,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int MEM_CNT_W     = 4
) (
    input logic                 clock,
    input logic                 reset,
    rob_recovery_ctrl_if.slave  bus
);
    localparam int GROUPS = ARCH_REGS / RESTORE_WIDTH;
    localparam int IDX_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int DCNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FLUSH    = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_RESTORE  = 3'd3;
    localparam logic [2:0] S_REDIRECT = 3'd4;
    localparam logic [2:0] S_HALTED   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [31:0]       target_q, target_d;
    logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              drain_timeout_q, drain_timeout_d;
    logic [15:0]       recovery_cycles_q, recovery_cycles_d;

    logic              drained;
    assign drained = bus.sq_empty && (bus.mem_outstanding == '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d           = state_q;
        target_d          = target_q;
        drain_cnt_d       = drain_cnt_q;
        idx_d             = idx_q;
        drain_timeout_d   = drain_timeout_q;
        recovery_cycles_d = recovery_cycles_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.ct_halt) begin
                    state_d = S_HALTED;
                end else if (bus.squash) begin
                    target_d = bus.squash_target;
                    state_d  = S_FLUSH;
                end
            end
            S_FLUSH: begin
                drain_cnt_d = '0;
                state_d     = S_DRAIN;
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + DCNT_W'(1);
                if (drained) begin
                    idx_d   = '0;
                    state_d = S_RESTORE;
                end else if (drain_cnt_q == DCNT_W'(DRAIN_TIMEOUT - 1)) begin
                    drain_timeout_d = 1'b1;
                    idx_d           = '0;
                    state_d         = S_RESTORE;
                end
            end
            S_RESTORE: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(GROUPS - 1)) state_d = S_REDIRECT;
            end
            S_REDIRECT: state_d = S_IDLE;
            S_HALTED:   state_d = S_HALTED;
            default:    state_d = S_IDLE;
        endcase

        // Perf counter covers only the active recovery states and never wraps.
        if ((state_q == S_FLUSH || state_q == S_DRAIN || state_q == S_RESTORE ||
             state_q == S_REDIRECT) && recovery_cycles_q != 16'hFFFF) begin
            recovery_cycles_d = recovery_cycles_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q           <= S_IDLE;
            target_q          <= '0;
            drain_cnt_q       <= '0;
            idx_q             <= '0;
            drain_timeout_q   <= 1'b0;
            recovery_cycles_q <= '0;
        end else begin
            state_q           <= state_d;
            target_q          <= target_d;
            drain_cnt_q       <= drain_cnt_d;
            idx_q             <= idx_d;
            drain_timeout_q   <= drain_timeout_d;
            recovery_cycles_q <= recovery_cycles_d;
        end
    end

    assign bus.flush            = (state_q == S_FLUSH);
    assign bus.stall_dispatch   = (state_q != S_IDLE);
    assign bus.restore_valid    = (state_q == S_RESTORE);
    assign bus.restore_arn_base = (state_q == S_RESTORE) ? 5'(idx_q * RESTORE_WIDTH) : 5'd0;
    assign bus.redirect_valid   = (state_q == S_REDIRECT);
    assign bus.redirect_pc      = (state_q == S_REDIRECT) ? target_q : 32'd0;
    assign bus.halted           = (state_q == S_HALTED);
    assign bus.drain_timeout    = drain_timeout_q;
    assign bus.recovery_cycles  = recovery_cycles_q;
endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Directed bench for rob_recovery_ctrl: normal recovery, slow drain, drain timeout,
// ignored second squash, halt priority and mid-recovery reset.
module tb_rob_recovery_ctrl;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    rob_recovery_ctrl_if #(.MEM_CNT_W(4)) bus ();

    rob_recovery_ctrl #(
        .ARCH_REGS(32), .RESTORE_WIDTH(4), .DRAIN_TIMEOUT(1024), .MEM_CNT_W(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance into the next cycle; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic squash_at(input logic [31:0] tgt);
        bus.squash        = 1'b1;
        bus.squash_target = tgt;
    endtask

    initial begin
        int redirect_c;
        n_cmp = 0;
        n_err = 0;
        bus.squash          = 1'b0;
        bus.squash_target   = 32'd0;
        bus.ct_halt         = 1'b0;
        bus.sq_empty        = 1'b1;
        bus.mem_outstanding = 4'd0;
        reset = 1'b0;
        #12;
        check("rst_stall",   {31'd0, bus.stall_dispatch}, 32'd0);
        check("rst_halted",  {31'd0, bus.halted}, 32'd0);
        check("rst_perf",    {16'd0, bus.recovery_cycles}, 32'd0);
        reset = 1'b1;
        step();

        // Normal recovery at minimum latency.
        squash_at(32'h0000_1040);
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) bus.squash = 1'b0;
            check($sformatf("t1_flush_c%0d", c), {31'd0, bus.flush}, {31'd0, c == 1});
            check($sformatf("t1_stall_c%0d", c), {31'd0, bus.stall_dispatch}, {31'd0, c >= 1 && c <= 11});
            check($sformatf("t1_rv_c%0d", c), {31'd0, bus.restore_valid}, {31'd0, c >= 3 && c <= 10});
            if (c >= 3 && c <= 10)
                check($sformatf("t1_arn_c%0d", c), {27'd0, bus.restore_arn_base}, 32'((c - 3) * 4));
            check($sformatf("t1_redir_c%0d", c), {31'd0, bus.redirect_valid}, {31'd0, c == 11});
            if (c == 11) check("t1_pc", bus.redirect_pc, 32'h0000_1040);
        end
        check("t1_perf", {16'd0, bus.recovery_cycles}, 32'd11);

        // Slow drain: outstanding ops clear in c7, RESTORE c8..c15, redirect c16.
        squash_at(32'h0000_2200);
        bus.mem_outstanding = 4'd3;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c == 1) bus.squash = 1'b0;
            if (c == 7) bus.mem_outstanding = 4'd0;
            if (c == 7 || c == 8)
                check($sformatf("t2_rv_c%0d", c), {31'd0, bus.restore_valid}, {31'd0, c == 8});
            if (c >= 15)
                check($sformatf("t2_redir_c%0d", c), {31'd0, bus.redirect_valid}, {31'd0, c == 16});
            if (c == 16) check("t2_pc", bus.redirect_pc, 32'h0000_2200);
        end
        check("t2_dto", {31'd0, bus.drain_timeout}, 32'd0);
        check("t2_perf", {16'd0, bus.recovery_cycles}, 32'd27);

        // Drain timeout: DRAIN c2..c1025, RESTORE c1026..c1033, redirect c1034.
        squash_at(32'h0000_5000);
        bus.sq_empty = 1'b0;
        redirect_c = -1;
        for (int c = 1; c <= 1100; c++) begin
            step();
            if (c == 1) bus.squash = 1'b0;
            if (c == 1025) check("t3_dto_pre", {31'd0, bus.drain_timeout}, 32'd0);
            if (bus.redirect_valid) begin
                redirect_c = c;
                break;
            end
        end
        check("t3_redir_cycle", 32'(redirect_c), 32'd1034);
        check("t3_pc", bus.redirect_pc, 32'h0000_5000);
        check("t3_dto", {31'd0, bus.drain_timeout}, 32'd1);
        step();
        bus.sq_empty = 1'b1;
        check("t3_perf", {16'd0, bus.recovery_cycles}, 32'd1061);

        // Second squash mid-recovery is ignored; sticky timeout flag survives.
        squash_at(32'h0000_3000);
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) bus.squash = 1'b0;
            if (c == 5) squash_at(32'h0000_2000);
            if (c == 6) bus.squash = 1'b0;
            if (c == 11) begin
                check("t4_redir", {31'd0, bus.redirect_valid}, 32'd1);
                check("t4_pc", bus.redirect_pc, 32'h0000_3000);
            end
        end
        check("t4_redir_off", {31'd0, bus.redirect_valid}, 32'd0);
        check("t4_dto", {31'd0, bus.drain_timeout}, 32'd1);
        check("t4_perf", {16'd0, bus.recovery_cycles}, 32'd1072);

        // Halt wins over simultaneous squash and is absorbing.
        squash_at(32'h0000_7000);
        bus.ct_halt = 1'b1;
        step();
        bus.squash  = 1'b0;
        bus.ct_halt = 1'b0;
        check("t5_halted", {31'd0, bus.halted}, 32'd1);
        check("t5_stall",  {31'd0, bus.stall_dispatch}, 32'd1);
        check("t5_flush",  {31'd0, bus.flush}, 32'd0);
        for (int c = 2; c <= 6; c++) begin
            if (c == 3) squash_at(32'h0000_7100);
            step();
            bus.squash = 1'b0;
            check($sformatf("t5_flush_c%0d", c), {31'd0, bus.flush}, 32'd0);
            check($sformatf("t5_halt_c%0d", c), {31'd0, bus.halted}, 32'd1);
        end
        check("t5_perf", {16'd0, bus.recovery_cycles}, 32'd1072);

        // Reset leaves HALTED.
        reset = 1'b0;
        #1;
        check("t6_halt_rst", {31'd0, bus.halted}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Reset during RESTORE (c6) aborts without a redirect.
        squash_at(32'h0000_9000);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) bus.squash = 1'b0;
        end
        check("t6_rv_before", {31'd0, bus.restore_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_stall", {31'd0, bus.stall_dispatch}, 32'd0);
        check("t6_rv",    {31'd0, bus.restore_valid}, 32'd0);
        check("t6_arn",   {27'd0, bus.restore_arn_base}, 32'd0);
        check("t6_perf",  {16'd0, bus.recovery_cycles}, 32'd0);
        check("t6_dto",   {31'd0, bus.drain_timeout}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("t6_redir_hold%0d", c), {31'd0, bus.redirect_valid}, 32'd0);
        end
        reset = 1'b1;
        step();

        // Fresh recovery after reset restarts the restore index at 0.
        squash_at(32'h0000_A000);
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) bus.squash = 1'b0;
            if (c == 3 || c == 4)
                check($sformatf("t7_arn_c%0d", c), {27'd0, bus.restore_arn_base}, 32'((c - 3) * 4));
            if (c == 11) check("t7_pc", bus.redirect_pc, 32'h0000_A000);
            if (c == 10 || c == 11 || c == 12)
                check($sformatf("t7_redir_c%0d", c), {31'd0, bus.redirect_valid}, {31'd0, c == 11});
        end
        check("t7_perf", {16'd0, bus.recovery_cycles}, 32'd11);
        check("t7_stall", {31'd0, bus.stall_dispatch}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
